// File: rtl/arf192b080e1r1w0cbbehbaa4acw_swt_pkg.sv
// Shared types, default sizing and the observation fold helper for the SWT observation unload path.
package arf192b080e1r1w0cbbehbaa4acw_swt_pkg;

    localparam int unsigned DEF_OBS_FLOP_NUM = 7;
    localparam int unsigned DEF_MISR_WIDTH   = 16;
    localparam logic [15:0] DEF_MISR_POLY    = 16'h1021;

    // Widest observation vector / signature the fold helper supports
    localparam int unsigned FOLD_MAX = 64;
    localparam int unsigned FOLD_IW  = $clog2(FOLD_MAX);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        UNLOAD = 1'b1
    } state_t;

    // Bit i of the observation vector lands on bit (i mod w) of the result
    function automatic logic [FOLD_MAX-1:0] fold(input logic [FOLD_MAX-1:0] obs,
                                                 input int unsigned         w);
        logic [FOLD_MAX-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < FOLD_MAX; i++) begin
            r[FOLD_IW'(i % w)] = r[FOLD_IW'(i % w)] ^ obs[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/arf192b080e1r1w0cbbehbaa4acw_swt_misr.sv
// Multiple-input signature register: Galois-style shift with polynomial feedback plus parallel data XOR.
module arf192b080e1r1w0cbbehbaa4acw_swt_misr #(
    parameter int unsigned     W    = 16,
    parameter logic [W-1:0]    POLY = W'(16'h1021)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_step,
    input  logic         i_clr,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_misr,
    output logic [W-1:0] o_next_c
);

    logic [W-1:0] r_misr;
    logic [W-1:0] w_step_val;

    always_comb begin
        w_step_val = {r_misr[W-2:0], 1'b0} ^ (r_misr[W-1] ? POLY : '0) ^ i_data;
        o_next_c   = i_step ? w_step_val : r_misr;
    end

    always_ff @(posedge clock) begin
        if (reset || i_clr) begin
            r_misr <= '0;
        end else if (i_step) begin
            r_misr <= w_step_val;
        end
    end

    assign o_misr = r_misr;

endmodule

// File: rtl/arf192b080e1r1w0cbbehbaa4acw_swt_obs_unload.sv
// SWT observation reader: compacts observation flops into a MISR and unloads a snapshot MSB-first
// over a valid/ready serial port.
module arf192b080e1r1w0cbbehbaa4acw_swt_obs_unload
    import arf192b080e1r1w0cbbehbaa4acw_swt_pkg::*;
#(
    parameter int unsigned              OBS_FLOP_NUM = DEF_OBS_FLOP_NUM,
    parameter int unsigned              MISR_WIDTH   = DEF_MISR_WIDTH,
    parameter logic [MISR_WIDTH-1:0]    MISR_POLY    = MISR_WIDTH'(DEF_MISR_POLY),
    parameter int unsigned              CNT_WIDTH    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [OBS_FLOP_NUM-1:0] obs_in,
    input  logic                    cap_en,
    input  logic                    unload_req,
    input  logic                    so_ready,
    output logic                    so_valid,
    output logic                    so_data,
    output logic                    so_last,
    output logic                    busy,
    output logic                    overrun,
    output logic [MISR_WIDTH-1:0]   misr_out,
    output logic [CNT_WIDTH-1:0]    sample_cnt
);

    localparam int unsigned BW = (MISR_WIDTH > 2) ? $clog2(MISR_WIDTH) : 1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [MISR_WIDTH-1:0]  r_shift;
    logic [BW-1:0]          r_bitcnt;
    logic [CNT_WIDTH-1:0]   r_sample_cnt;
    logic                   r_overrun;
    logic [MISR_WIDTH-1:0]  w_fold;
    logic [MISR_WIDTH-1:0]  w_misr_nxt;
    logic                   w_idle;
    logic                   w_cap;
    logic                   w_start;
    logic                   w_xfer;
    logic                   w_done;

    assign w_idle  = (r_state == IDLE);
    assign w_cap   = cap_en & w_idle;
    assign w_start = unload_req & w_idle;
    assign w_xfer  = (r_state == UNLOAD) & so_ready;
    assign w_done  = w_xfer & (r_bitcnt == '0);
    assign w_fold  = MISR_WIDTH'(fold(FOLD_MAX'(obs_in), MISR_WIDTH));

    arf192b080e1r1w0cbbehbaa4acw_swt_misr #(
        .W    (MISR_WIDTH),
        .POLY (MISR_POLY)
    ) u_misr (
        .clock    (clock),
        .reset    (reset),
        .i_step   (w_cap),
        .i_clr    (w_done),
        .i_data   (w_fold),
        .o_misr   (misr_out),
        .o_next_c (w_misr_nxt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (unload_req) w_state_nxt = UNLOAD;
            UNLOAD:  if (w_done)     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        so_valid = 1'b0;
        busy     = 1'b0;
        so_data  = 1'b0;
        so_last  = 1'b0;
        if (r_state == UNLOAD) begin
            so_valid = 1'b1;
            busy     = 1'b1;
            so_data  = r_shift[MISR_WIDTH-1];
            so_last  = (r_bitcnt == '0);
        end
    end

    // Snapshot includes a same-cycle capture because it loads the MISR next value
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else if (w_start) begin
            r_shift  <= w_misr_nxt;
            r_bitcnt <= BW'(MISR_WIDTH - 1);
        end else if (w_xfer) begin
            r_shift  <= {r_shift[MISR_WIDTH-2:0], 1'b0};
            r_bitcnt <= r_bitcnt - BW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_done) begin
            r_sample_cnt <= '0;
        end else if (w_cap && (r_sample_cnt != '1)) begin
            r_sample_cnt <= r_sample_cnt + CNT_WIDTH'(1);
        end
    end

    // Sticky until the next unload starts: a capture arrived while the MISR was frozen
    always_ff @(posedge clock) begin
        if (reset || w_start) begin
            r_overrun <= 1'b0;
        end else if (cap_en && !w_idle) begin
            r_overrun <= 1'b1;
        end
    end

    assign sample_cnt = r_sample_cnt;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_arf192b080e1r1w0cbbehbaa4acw_swt_obs_unload.sv
// Directed bench for the SWT observation unload block; expected signatures are hand-computed.
module tb_arf192b080e1r1w0cbbehbaa4acw_swt_obs_unload;

    logic        clock;
    logic        reset;
    logic [6:0]  obs_in;
    logic        cap_en;
    logic        unload_req;
    logic        so_ready;
    logic        so_valid;
    logic        so_data;
    logic        so_last;
    logic        busy;
    logic        overrun;
    logic [15:0] misr_out;
    logic [15:0] sample_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    arf192b080e1r1w0cbbehbaa4acw_swt_obs_unload dut (
        .clock      (clock),
        .reset      (reset),
        .obs_in     (obs_in),
        .cap_en     (cap_en),
        .unload_req (unload_req),
        .so_ready   (so_ready),
        .so_valid   (so_valid),
        .so_data    (so_data),
        .so_last    (so_last),
        .busy       (busy),
        .overrun    (overrun),
        .misr_out   (misr_out),
        .sample_cnt (sample_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled at the falling edge
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic cap(input logic [6:0] v);
        obs_in = v;
        cap_en = 1'b1;
        tick();
        cap_en = 1'b0;
        obs_in = '0;
    endtask

    // Drain an unload already in progress; ready either held high or toggled 1,0,0,1,0,0,...
    task automatic drain(input string tag, input logic [15:0] exp, input bit toggle);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < 16 && cyc < 200) begin
            so_ready = toggle ? ((cyc % 3) == 0) : 1'b1;
            chk({tag, "_valid"}, 32'(so_valid), 32'd1);
            chk({tag, "_data"},  32'(so_data),  32'(exp[15-k]));
            chk({tag, "_last"},  32'(so_last),  32'(k == 15));
            if (so_ready) k++;
            tick();
            cyc++;
        end
        so_ready = 1'b0;
        chk({tag, "_budget"}, 32'(cyc < 200), 32'd1);
        chk({tag, "_busy_end"},  32'(busy),       32'd0);
        chk({tag, "_valid_end"}, 32'(so_valid),   32'd0);
        chk({tag, "_misr_end"},  32'(misr_out),   32'd0);
        chk({tag, "_cnt_end"},   32'(sample_cnt), 32'd0);
    endtask

    task automatic start();
        unload_req = 1'b1;
        tick();
        unload_req = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        obs_in     = '0;
        cap_en     = 1'b0;
        unload_req = 1'b0;
        so_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid",   32'(so_valid),   32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_last",    32'(so_last),    32'd0);
        chk("rst_data",    32'(so_data),    32'd0);
        chk("rst_overrun", 32'(overrun),    32'd0);
        chk("rst_misr",    32'(misr_out),   32'd0);
        chk("rst_cnt",     32'(sample_cnt), 32'd0);

        // Single capture then full-rate unload
        cap(7'h55);
        chk("s1_misr", 32'(misr_out),   32'h0055);
        chk("s1_cnt",  32'(sample_cnt), 32'd1);
        start();
        chk("s1_busy", 32'(busy), 32'd1);
        drain("s1", 16'h0055, 1'b0);

        // Shift-only steps, then one step that hits the feedback taps
        cap(7'h55);
        for (int i = 0; i < 9; i++) cap(7'h00);
        chk("s2_misr_aa00", 32'(misr_out),   32'hAA00);
        chk("s2_cnt",       32'(sample_cnt), 32'd10);
        cap(7'h00);
        chk("s2_misr_4421", 32'(misr_out),   32'h4421);
        start();
        drain("s2", 16'h4421, 1'b0);

        // Back-pressured unload
        cap(7'h55);
        start();
        drain("s3", 16'h0055, 1'b1);

        // Capture and unload start in the same cycle
        obs_in     = 7'h01;
        cap_en     = 1'b1;
        unload_req = 1'b1;
        tick();
        cap_en     = 1'b0;
        unload_req = 1'b0;
        obs_in     = '0;
        chk("s4_misr", 32'(misr_out), 32'h0001);
        chk("s4_busy", 32'(busy),     32'd1);
        drain("s4", 16'h0001, 1'b0);

        // Capture during unload is dropped and flagged
        cap(7'h55);
        start();
        obs_in = 7'h7F;
        cap_en = 1'b1;
        tick();
        cap_en = 1'b0;
        obs_in = '0;
        chk("s5_overrun",   32'(overrun),  32'd1);
        chk("s5_misr_frz",  32'(misr_out), 32'h0055);
        chk("s5_cnt_frz",   32'(sample_cnt), 32'd1);
        unload_req = 1'b1;
        tick();
        unload_req = 1'b0;
        chk("s5_req_ignored", 32'(so_data), 32'd0);
        drain("s5", 16'h0055, 1'b0);
        chk("s5_overrun_sticky", 32'(overrun), 32'd1);
        start();
        chk("s5_overrun_clr", 32'(overrun), 32'd0);
        drain("s5b", 16'h0000, 1'b0);

        // Reset while the fifth bit is on the wire
        cap(7'h55);
        start();
        so_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("s6_bit5_valid", 32'(so_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        so_ready = 1'b0;
        chk("s6_valid", 32'(so_valid),   32'd0);
        chk("s6_busy",  32'(busy),       32'd0);
        chk("s6_last",  32'(so_last),    32'd0);
        chk("s6_misr",  32'(misr_out),   32'd0);
        chk("s6_cnt",   32'(sample_cnt), 32'd0);
        cap(7'h03);
        chk("s6_misr_new", 32'(misr_out), 32'h0003);
        start();
        drain("s6", 16'h0003, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
